// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: identifier FSM states and identifier constants.
package can_pkg;

  localparam int CAN_ID_WIDTH = 11;
  localparam logic [6:0] CAN_ID_RESERVED_PREFIX = 7'b1111111;
  localparam logic [CAN_ID_WIDTH-1:0] CAN_ID_IDLE = 11'h7FF;

  typedef enum logic [1:0] {
    RX_IDLE        = 2'd0,
    RX_RECEIVE_ID  = 2'd1,
    RX_RECEIVE_RTR = 2'd2,
    RX_DONE        = 2'd3
  } rx_id_state_t;

  // An identifier whose seven MSBs are all recessive may not be used on the bus.
  function automatic logic id_is_reserved(input logic [CAN_ID_WIDTH-1:0] id);
    return (id[CAN_ID_WIDTH-1 -: 7] == CAN_ID_RESERVED_PREFIX);
  endfunction

endpackage

// File: rtl/id_acceptance_filter.sv
// Combinational acceptance filter: a mask bit of 1 means the identifier bit must equal the code bit.
module id_acceptance_filter #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] i_identifier,
  input  logic [WIDTH-1:0] i_code,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_match
);

  logic [WIDTH-1:0] w_diff;

  assign w_diff  = (i_identifier ^ i_code) & i_mask;
  assign o_match = (w_diff == '0);

endmodule

// File: rtl/identifier_receiver.sv
// Deserializes the 11-bit standard identifier and RTR bit after SOF, classifies the
// identifier (reserved / accepted) and pulses completion for one cycle.
module identifier_receiver
  import can_pkg::*;
#(
  parameter int ID_WIDTH = CAN_ID_WIDTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sample_point,
  input  logic                stuff_bit_detected,
  input  logic                sof_detected,
  input  logic                rx_bit,
  input  logic                error_abort,
  input  logic [ID_WIDTH-1:0] acceptance_code,
  input  logic [ID_WIDTH-1:0] acceptance_mask,
  output logic [ID_WIDTH-1:0] rx_identifier,
  output logic                rx_rtr,
  output logic [3:0]          id_counter,
  output logic                id_valid,
  output logic                id_accepted,
  output logic                id_format_error,
  output logic                id_rx_complete
);

  rx_id_state_t        r_state;
  rx_id_state_t        w_next;
  logic [ID_WIDTH-1:0] r_shift;
  logic [ID_WIDTH-1:0] r_rx_id;
  logic                r_rtr;
  logic [3:0]          r_count;
  logic                r_valid;
  logic                r_accepted;
  logic                w_qual;
  logic                w_last_id_bit;
  logic                w_match;
  logic                w_shift_valid;
  logic                w_complete;
  logic                w_format_error;

  // Stuff bits are removed from the data stream: only these samples carry frame content.
  assign w_qual        = sample_point & ~stuff_bit_detected;
  assign w_last_id_bit = (r_count == 4'(ID_WIDTH - 1));
  assign w_shift_valid = ~id_is_reserved(r_shift);

  id_acceptance_filter #(
    .WIDTH(ID_WIDTH)
  ) u_filter (
    .i_identifier(r_shift),
    .i_code      (acceptance_code),
    .i_mask      (acceptance_mask),
    .o_match     (w_match)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and completion outputs; disable and abort override every transition.
  always_comb begin
    w_next         = r_state;
    w_complete     = 1'b0;
    w_format_error = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (sof_detected) w_next = RX_RECEIVE_ID;
      end
      RX_RECEIVE_ID: begin
        if (w_qual && w_last_id_bit) w_next = RX_RECEIVE_RTR;
      end
      RX_RECEIVE_RTR: begin
        if (w_qual) w_next = RX_DONE;
      end
      RX_DONE: begin
        w_complete     = 1'b1;
        w_format_error = ~r_valid;
        w_next         = RX_IDLE;
      end
      default: w_next = RX_IDLE;
    endcase
    if (!enable || error_abort) w_next = RX_IDLE;
  end

  // Shift register, bit counter and held capture registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= CAN_ID_IDLE;
      r_count    <= 4'd0;
      r_rx_id    <= CAN_ID_IDLE;
      r_rtr      <= 1'b1;
      r_valid    <= 1'b0;
      r_accepted <= 1'b0;
    end else if (!enable) begin
      r_shift    <= CAN_ID_IDLE;
      r_count    <= 4'd0;
      r_rx_id    <= CAN_ID_IDLE;
      r_rtr      <= 1'b1;
      r_valid    <= 1'b0;
      r_accepted <= 1'b0;
    end else if (error_abort) begin
      // Abandon the frame but keep the last good capture visible.
      r_shift <= CAN_ID_IDLE;
      r_count <= 4'd0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_shift <= CAN_ID_IDLE;
          r_count <= 4'd0;
        end
        RX_RECEIVE_ID: begin
          if (w_qual && (r_count < 4'(ID_WIDTH))) begin
            r_shift <= {r_shift[ID_WIDTH-2:0], rx_bit};
            r_count <= r_count + 4'd1;
          end
        end
        RX_RECEIVE_RTR: begin
          if (w_qual) begin
            r_rx_id    <= r_shift;
            r_rtr      <= rx_bit;
            r_valid    <= w_shift_valid;
            r_accepted <= w_shift_valid & w_match;
          end
        end
        RX_DONE: begin
          r_count <= 4'd0;
        end
        default: begin
          r_count <= 4'd0;
        end
      endcase
    end
  end

  assign rx_identifier   = r_rx_id;
  assign rx_rtr          = r_rtr;
  assign id_counter      = r_count;
  assign id_valid        = r_valid;
  assign id_accepted     = r_accepted;
  assign id_format_error = w_format_error;
  assign id_rx_complete  = w_complete;

endmodule

// File: tb/tb_identifier_receiver.sv
// Bench for identifier_receiver: table-driven frames, hand-written corner sequences and
// randomized frames, all compared every cycle against a queue-based frame model.
module tb_identifier_receiver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        sample_point = 1'b0;
  logic        stuff_bit_detected = 1'b0;
  logic        sof_detected = 1'b0;
  logic        rx_bit = 1'b1;
  logic        error_abort = 1'b0;
  logic [10:0] acceptance_code = 11'h000;
  logic [10:0] acceptance_mask = 11'h000;
  logic [10:0] rx_identifier;
  logic        rx_rtr;
  logic [3:0]  id_counter;
  logic        id_valid;
  logic        id_accepted;
  logic        id_format_error;
  logic        id_rx_complete;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  identifier_receiver #(.ID_WIDTH(11)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .sample_point      (sample_point),
    .stuff_bit_detected(stuff_bit_detected),
    .sof_detected      (sof_detected),
    .rx_bit            (rx_bit),
    .error_abort       (error_abort),
    .acceptance_code   (acceptance_code),
    .acceptance_mask   (acceptance_mask),
    .rx_identifier     (rx_identifier),
    .rx_rtr            (rx_rtr),
    .id_counter        (id_counter),
    .id_valid          (id_valid),
    .id_accepted       (id_accepted),
    .id_format_error   (id_format_error),
    .id_rx_complete    (id_rx_complete)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // m_bits holds the data bits of the current frame in bus order; its size is the bit count.
  logic        m_bits[$];
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  logic [10:0] m_id = 11'h7FF;
  logic        m_rtr = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_acc = 1'b0;

  task automatic model_clear_captures();
    m_id = 11'h7FF; m_rtr = 1'b1; m_valid = 1'b0; m_acc = 1'b0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || !enable) begin
      m_bits.delete(); m_active = 1'b0; m_done = 1'b0;
      model_clear_captures();
    end else if (error_abort) begin
      m_bits.delete(); m_active = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      m_bits.delete(); m_done = 1'b0;
    end else if (!m_active) begin
      m_bits.delete();
      if (sof_detected) m_active = 1'b1;
    end else if (sample_point && !stuff_bit_detected) begin
      if (m_bits.size() < 11) begin
        m_bits.push_back(rx_bit);
      end else begin
        int v;
        v = 0;
        foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
        m_id    = 11'(v);
        m_rtr   = rx_bit;
        m_valid = ((v / 16) != 127);
        m_acc   = m_valid;
        for (int i = 0; i < 11; i++)
          if (acceptance_mask[i] && (m_id[i] != acceptance_code[i])) m_acc = 1'b0;
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  // Every cycle the DUT outputs must equal the model's view of the frame.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("lockstep",
          {rx_identifier, rx_rtr, id_counter, id_valid, id_accepted, id_format_error, id_rx_complete},
          {m_id, m_rtr, 4'(m_bits.size()), m_valid, m_acc, m_done && !m_valid, m_done});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic sp, input logic st, input logic sof, input logic b, input logic ab);
    @(posedge clock);
    #2;
    sample_point = sp; stuff_bit_detected = st; sof_detected = sof; rx_bit = b; error_abort = ab;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // SOF, then 11 identifier bits MSB first and the RTR bit; stuff[i] inserts a stuff sample
  // before data bit i, gaps of up to gap_max idle cycles, optional spurious SOF pulses.
  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [11:0] stuff,
                            input int gap_max, input bit spur);
    logic b;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      b = (i < 11) ? id[10 - i] : rtr;
      if (stuff[i]) drive(1'b1, 1'b1, 1'b0, ~b, 1'b0);
      repeat ($urandom_range(0, gap_max)) idle();
      drive(1'b1, 1'b0, spur && ($urandom_range(0, 3) == 0), b, 1'b0);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic partial_frame(input logic [10:0] id, input int nbits);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) drive(1'b1, 1'b0, 1'b0, id[10 - i], 1'b0);
  endtask

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [10:0] code;
    logic [10:0] mask;
    logic [11:0] stuff;
    logic        exp_valid;
    logic        exp_acc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{11'h123, 1'b0, 11'h000, 11'h000, 12'h000, 1'b1, 1'b1};
    vecs[1] = '{11'h123, 1'b0, 11'h000, 11'h000, 12'h092, 1'b1, 1'b1};
    vecs[2] = '{11'h12F, 1'b1, 11'h120, 11'h7F0, 12'h000, 1'b1, 1'b1};
    vecs[3] = '{11'h133, 1'b0, 11'h120, 11'h7F0, 12'h000, 1'b1, 1'b0};
    vecs[4] = '{11'h7F5, 1'b0, 11'h000, 11'h000, 12'h000, 1'b0, 1'b0};
    vecs[5] = '{11'h7EF, 1'b1, 11'h7EF, 11'h7FF, 12'h801, 1'b1, 1'b1};
    vecs[6] = '{11'h000, 1'b1, 11'h001, 11'h001, 12'h400, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_id", rx_identifier, 11'h7FF);
    chk("reset_rtr", rx_rtr, 1'b1);
    chk("reset_cnt", id_counter, 4'd0);
    chk("reset_flags", {id_valid, id_accepted, id_format_error, id_rx_complete}, 4'b0000);
    @(posedge clock);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) idle();

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      acceptance_code = vecs[k].code;
      acceptance_mask = vecs[k].mask;
      send_frame(vecs[k].id, vecs[k].rtr, vecs[k].stuff, 0, 1'b0);
      chk($sformatf("tbl%0d_id", k), rx_identifier, vecs[k].id);
      chk($sformatf("tbl%0d_rtr", k), rx_rtr, vecs[k].rtr);
      chk($sformatf("tbl%0d_cnt", k), id_counter, 4'd11);
      chk($sformatf("tbl%0d_valid", k), id_valid, vecs[k].exp_valid);
      chk($sformatf("tbl%0d_acc", k), id_accepted, vecs[k].exp_acc);
      chk($sformatf("tbl%0d_done", k), {id_rx_complete, id_format_error}, {1'b1, ~vecs[k].exp_valid});
      idle();
      @(negedge clock);
      chk($sformatf("tbl%0d_pulse_end", k), {id_rx_complete, id_format_error, id_counter}, 6'd0);
    end

    // Abort after 6 bits (with a qualified sample on the abort cycle) keeps the old capture
    acceptance_mask = 11'h000;
    send_frame(11'h123, 1'b0, 12'h000, 1, 1'b0);
    partial_frame(11'h555, 6);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    @(negedge clock);
    chk("abort_cnt", id_counter, 4'd0);
    chk("abort_id", rx_identifier, 11'h123);
    chk("abort_nopulse", id_rx_complete, 1'b0);
    send_frame(11'h0AA, 1'b1, 12'h000, 0, 1'b0);
    chk("after_abort_id", {rx_identifier, rx_rtr, id_rx_complete}, {11'h0AA, 1'b1, 1'b1});

    // Abort wins over a simultaneous SOF: the next sample is not counted
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clock);
    chk("abort_sof_cnt", id_counter, 4'd0);

    // Asynchronous reset mid-identifier clears held captures immediately
    partial_frame(11'h3C3, 4);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst", {rx_identifier, rx_rtr, id_counter, id_valid, id_accepted, id_rx_complete},
        {11'h7FF, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
    idle();
    reset_n = 1'b1;
    send_frame(11'h2B4, 1'b0, 12'h000, 0, 1'b0);
    chk("after_rst_id", rx_identifier, 11'h2B4);

    // Enable low for one cycle mid-frame
    partial_frame(11'h1FF, 5);
    idle();
    enable = 1'b0;
    idle();
    enable = 1'b1;
    @(negedge clock);
    chk("en_low", {rx_identifier, rx_rtr, id_counter, id_valid, id_rx_complete},
        {11'h7FF, 1'b1, 4'd0, 1'b0, 1'b0});
    send_frame(11'h555, 1'b1, 12'h000, 0, 1'b0);
    chk("after_en_id", {rx_identifier, rx_rtr}, {11'h555, 1'b1});

    // Randomized frames, aborts and spurious SOFs against the model
    for (int n = 0; n < 250; n++) begin
      logic [10:0] rid;
      rid = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) rid[10:4] = 7'h7F;
      acceptance_code = 11'($urandom);
      acceptance_mask = ($urandom_range(0, 1) == 1) ? 11'($urandom) & 11'h7F0 : 11'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        partial_frame(rid, $urandom_range(0, 11));
        drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end else begin
        send_frame(rid, 1'($urandom_range(0, 1)), 12'($urandom), 2, 1'b1);
      end
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();
    @(negedge clock);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/identifier_receiver.md
# identifier_receiver

Receive-side counterpart of the CAN identifier transmitter: deserializes the 11-bit standard identifier and the RTR bit from the destuffed bus bit stream after Start-of-Frame. It checks the identifier against the reserved-ID rule and an acceptance code/mask filter, then reports the result with a one-cycle completion pulse. It sits in the receive data-frame path between the bit destuffer/bit-timing logic and the control-field receiver.

## Interface
- ID_WIDTH, 11, standard CAN identifier width; only 11 is supported.
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low forces a synchronous return to IDLE with all outputs at reset values.
- sample_point  input  1  one-cycle strobe marking the bus sample instant.
- stuff_bit_detected  input  1  the current sample is a stuff bit and must be discarded.
- sof_detected  input  1  one-cycle pulse: SOF received; the next qualified sample is identifier bit 10.
- rx_bit  input  1  sampled bus level (0 = dominant).
- error_abort  input  1  frame error from the error logic; abandons reception.
- acceptance_code  input  11  identifier compare value.
- acceptance_mask  input  11  1 = compare this bit, 0 = don't care.
- rx_identifier  output  11  last completed identifier, MSB first on the bus; reset 11'h7FF.
- rx_rtr  output  1  last completed RTR bit; reset 1.
- id_counter  output  4  identifier bits received in the current frame, 0..11; reset 0.
- id_valid  output  1  rx_identifier[10:4] != 7'b1111111; reset 0.
- id_accepted  output  1  id_valid and filter match; reset 0.
- id_format_error  output  1  one-cycle pulse with id_rx_complete when the identifier is reserved; reset 0.
- id_rx_complete  output  1  one-cycle pulse: identifier and RTR captured; reset 0.

## Operation
- Qualified sample: sample_point && !stuff_bit_detected. Every other cycle is ignored for data.
- States: IDLE, RECEIVE_ID, RECEIVE_RTR, DONE.
- IDLE:
  - sof_detected moves to RECEIVE_ID.
  - The shift register loads 11'h7FF and id_counter loads 0.
- RECEIVE_ID:
  - Each qualified sample shifts rx_bit into the shift register LSB (shift left) and increments id_counter.
  - The sample taken with id_counter == 10 is the 11th bit. id_counter becomes 11 and the state moves to RECEIVE_RTR.
- RECEIVE_RTR:
  - The next qualified sample captures RTR.
  - On that same edge, update rx_identifier, rx_rtr, id_valid and id_accepted, and move to DONE.
- DONE:
  - id_rx_complete = 1. id_format_error = !id_valid.
  - Unconditionally return to IDLE.
- Filter: match = ((shift ^ acceptance_code) & acceptance_mask) == 0, evaluated at capture time. id_accepted = id_valid && match.
- rx_identifier, rx_rtr, id_valid and id_accepted hold their values until the next successful capture.

## Timing
- Pipeline:
  - The SOF pulse at edge N puts the block in RECEIVE_ID at N+1.
  - The RTR qualified sample at edge M produces registered outputs and id_rx_complete=1 in the cycle after M.
  - id_rx_complete returns to 0 one cycle later.
- error_abort in any state returns to IDLE on the next edge:
  - no completion pulse;
  - captured outputs keep their previous values;
  - id_counter goes to 0.
- Simultaneous events:
  - error_abort wins over sof_detected and over a qualified sample.
  - sof_detected outside IDLE is ignored.
  - sof_detected during DONE is ignored; the block goes to IDLE.
- A sample_point with stuff_bit_detected=1 changes no state, counter or shift register.
- Back-to-back sample_point on consecutive cycles is legal; each one is processed.
- enable low or reset_n low mid-frame: immediate (reset) or next-edge (enable) return to IDLE with reset values on all outputs, including the held captures.
- id_counter never exceeds 11 and never wraps.

## Structure
- Shared package can_pkg holds:
  - the rx_id_state_t enum (2 bits);
  - CAN_ID_WIDTH = 11;
  - CAN_ID_RESERVED_PREFIX = 7'b1111111;
  - CAN_ID_IDLE = 11'h7FF.
- One combinational sub-module, id_acceptance_filter (identifier, code, mask -> match). The same filter is reused by later extended-ID work.
- The FSM and datapath stay in identifier_receiver.

## Test plan
- SOF, then ID 11'h123 and RTR=0 with no stuff bits -> rx_identifier=11'h123, rx_rtr=0, id_valid=1, id_counter=11, one id_rx_complete pulse.
- Same frame with stuff_bit_detected=1 on three samples inside the ID -> identical capture; those three samples are not counted.
- Mask 11'h7F0, code 11'h120; ID 11'h12F -> id_accepted=1. ID 11'h133 -> id_accepted=0 and id_valid=1.
- ID 11'h7F5 (reserved prefix) -> id_valid=0, id_accepted=0, id_format_error pulses with id_rx_complete.
- error_abort after 6 ID bits, following a prior capture of 11'h123 -> IDLE, no pulse, rx_identifier stays 11'h123, id_counter=0. A following clean frame with ID 11'h0AA captures correctly.
- reset_n low mid-RECEIVE_ID -> all outputs at reset values. enable low for one cycle mid-frame -> IDLE, and a later SOF restarts cleanly.
